core_mem_stage: RTL and testbench
=================================

CORE_MEM_STAGE -- requirements
Module: core_mem_stage

Interface
REQ-001 SHALL have parameter: XLEN, default 32, datapath width.
REQ-002 SHALL have port: i_clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: i_valid in 1 instr valid; i_opcode in 7; i_funct3 in 3; i_rd in 5; i_reg_write in 1.
REQ-005 SHALL have ports: i_alu_result in XLEN, address or result; i_store_data in XLEN, forwarded rs2.
REQ-006 SHALL have dmem ports: o_dmem_req out 1; o_dmem_we out 1; o_dmem_addr out XLEN (word-aligned); o_dmem_wdata out XLEN; o_dmem_be out 4.
REQ-007 SHALL have dmem response ports: i_dmem_gnt in 1; i_dmem_rvalid in 1; i_dmem_rdata in XLEN.
REQ-008 SHALL have ports: o_stall out 1, hold upstream; o_misaligned out 1, exception pulse.
REQ-009 SHALL have writeback ports: o_wb_valid out 1; o_wb_rd out 5; o_wb_reg_write out 1; o_wb_data out XLEN.

Function
REQ-010 SHALL implement FSM states IDLE and WAIT; WAIT is entered only by a granted load.
REQ-011 Non-memory valid instr in IDLE: no request, no stall; wb registers capture rd/reg_write/i_alu_result next edge.
REQ-012 Memory op (opcode 0000011 load, 0100011 store) valid and aligned in IDLE: o_dmem_req=1 combinationally, held with stable inputs until i_dmem_gnt.
REQ-013 Store SHALL complete on the gnt cycle: o_stall=0 in that cycle; wb captures with o_wb_reg_write=0.
REQ-014 Load: o_stall=1 from issue until the i_dmem_rvalid cycle (inclusive stall=0); gnt moves IDLE->WAIT; rvalid in WAIT returns to IDLE and captures extended data.
REQ-015 rvalid in the same cycle as gnt SHALL be illegal; rvalid in IDLE SHALL be ignored.
REQ-016 o_dmem_addr = {i_alu_result[XLEN-1:2],2'b00}; o_dmem_we=1 for stores only.
REQ-017 Store lanes: SB be=4'b0001<<addr[1:0], wdata=byte replicated x4; SH be=4'b0011<<addr[1:0], half replicated x2; SW be=4'b1111.
REQ-018 Load extract by addr[1:0]: LB(000)/LH(001) sign-extend, LW(010) whole word, LBU(100)/LHU(101) zero-extend.
REQ-019 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no request, no stall, o_misaligned=1 for one cycle after edge, o_wb_valid=1 with o_wb_reg_write=0.
REQ-020 o_wb_valid SHALL be a one-cycle pulse per completed instr; wb outputs are registered, latency 1 edge after completion.
REQ-021 i_valid=0 SHALL produce no request and o_wb_valid=0 next cycle.
REQ-022 Unsupported funct3 on a memory op SHALL be treated as LW/SW.

Reset
REQ-023 On i_rst_n=0 (any time, incl. WAIT), state->IDLE; o_wb_valid, o_wb_reg_write, o_misaligned, o_wb_rd, o_wb_data ->0.
REQ-024 In reset, o_dmem_req=0 and o_stall=0; a late rvalid after reset SHALL be dropped.

Structure
REQ-025 Opcode constants, load/store funct3 codes and FSM state enum SHALL live in shared package core_pkg.
REQ-026 Load extraction/extension SHALL be sub-module load_align (combinational: rdata, addr[1:0], funct3 -> XLEN data).

Verification
REQ-027 ADDI result 0x0000_0055, rd=5 -> one cycle later o_wb_valid=1, o_wb_rd=5, o_wb_data=0x55, no stall.
REQ-028 SB addr 0x1003 data 0xAB, gnt delayed 2 cycles -> req held 3 cycles, be=1000, wdata=0xABABABAB, addr=0x1000.
REQ-029 LB addr 0x2001, rdata 0x0000_8000 on rvalid 2 cycles after gnt -> o_wb_data=0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-030 LW addr 0x2002 -> no req, o_misaligned pulse, o_wb_reg_write=0.
REQ-031 Reset asserted in WAIT, then rvalid -> state IDLE, all wb outputs 0, rvalid ignored.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: opcodes, funct3 codes, FSM state and access-size helper shared by the memory stage.
package core_pkg;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic {IDLE, WAIT} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
   // Any funct3 outside the byte/half codes degrades to a word access.
   function automatic size_t access_size(input logic is_load, input logic [2:0] f3);
      return (f3 == F3_B || (is_load && f3 == F3_BU)) ? SZ_B :
             (f3 == F3_H || (is_load && f3 == F3_HU)) ? SZ_H : SZ_W;
   endfunction
endpackage

// File: rtl/core_mem_stage_if.sv
// core_mem_stage_if: data-memory request/response bus between the memory stage and dmem.
interface core_mem_stage_if #(parameter int XLEN = 32);
   logic            o_dmem_req;
   logic            o_dmem_we;
   logic [XLEN-1:0] o_dmem_addr;
   logic [XLEN-1:0] o_dmem_wdata;
   logic [3:0]      o_dmem_be;
   logic            i_dmem_gnt;
   logic            i_dmem_rvalid;
   logic [XLEN-1:0] i_dmem_rdata;
   modport master (
      output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
      input  i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
   );
   modport slave (
      input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
      output i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
   );
endinterface

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half/word out of a read word and sign- or zero-extends it.
module load_align import core_pkg::*; #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);
   logic [XLEN-1:0] sh;
   always_comb begin
      sh = rdata >> {addr_lo, 3'b000};
      data = funct3 == F3_B  ? {{(XLEN-8){sh[7]}}, sh[7:0]} :
             funct3 == F3_H  ? {{(XLEN-16){sh[15]}}, sh[15:0]} :
             funct3 == F3_BU ? {{(XLEN-8){1'b0}}, sh[7:0]} :
             funct3 == F3_HU ? {{(XLEN-16){1'b0}}, sh[15:0]} : rdata;
   end
endmodule

// File: rtl/core_mem_stage.sv
// core_mem_stage: issues loads/stores to dmem, stalls on outstanding loads and registers the writeback.
module core_mem_stage import core_pkg::*; #(
   parameter int XLEN = 32
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_valid,
   input  logic [6:0]          i_opcode,
   input  logic [2:0]          i_funct3,
   input  logic [4:0]          i_rd,
   input  logic                i_reg_write,
   input  logic [XLEN-1:0]     i_alu_result,
   input  logic [XLEN-1:0]     i_store_data,
   core_mem_stage_if.master    dmem,
   output logic                o_stall,
   output logic                o_misaligned,
   output logic                o_wb_valid,
   output logic [4:0]          o_wb_rd,
   output logic                o_wb_reg_write,
   output logic [XLEN-1:0]     o_wb_data
);
   state_t          state;
   logic [4:0]      ld_rd;
   logic            ld_reg_write;
   logic [2:0]      ld_f3;
   logic [1:0]      ld_off;
   logic [XLEN-1:0] ld_data;
   logic            is_load, is_store, is_mem, misaligned, issue;
   logic [1:0]      off;
   size_t           size;
   always_comb begin
      is_load    = i_opcode == OP_LOAD;
      is_store   = i_opcode == OP_STORE;
      is_mem     = is_load || is_store;
      size       = access_size(is_load, i_funct3);
      off        = i_alu_result[1:0];
      misaligned = (size == SZ_H && off[0]) || (size == SZ_W && off != 2'b00);
      issue      = i_rst_n && state == IDLE && i_valid && is_mem && !misaligned;
      dmem.o_dmem_req   = issue;
      dmem.o_dmem_we    = issue && is_store;
      dmem.o_dmem_addr  = {i_alu_result[XLEN-1:2], 2'b00};
      dmem.o_dmem_be    = !is_store ? 4'b1111 :
                          size == SZ_B ? 4'b0001 << off :
                          size == SZ_H ? 4'b0011 << off : 4'b1111;
      dmem.o_dmem_wdata = size == SZ_B ? {(XLEN/8){i_store_data[7:0]}} :
                          size == SZ_H ? {(XLEN/16){i_store_data[15:0]}} : i_store_data;
      // A load stalls through its grant; a store only until granted.
      o_stall = i_rst_n && (state == WAIT ? !dmem.i_dmem_rvalid :
                            issue && (is_load || !dmem.i_dmem_gnt));
   end
   load_align #(.XLEN(XLEN)) u_load_align (
      .rdata   (dmem.i_dmem_rdata),
      .addr_lo (ld_off),
      .funct3  (ld_f3),
      .data    (ld_data)
   );
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= IDLE;
         o_wb_valid     <= 1'b0;
         o_wb_rd        <= '0;
         o_wb_reg_write <= 1'b0;
         o_wb_data      <= '0;
         o_misaligned   <= 1'b0;
         ld_rd          <= '0;
         ld_reg_write   <= 1'b0;
         ld_f3          <= '0;
         ld_off         <= '0;
      end else begin
         o_wb_valid   <= 1'b0;
         o_misaligned <= 1'b0;
         if (state == WAIT) begin
            if (dmem.i_dmem_rvalid) begin
               state          <= IDLE;
               o_wb_valid     <= 1'b1;
               o_wb_rd        <= ld_rd;
               o_wb_reg_write <= ld_reg_write;
               o_wb_data      <= ld_data;
            end
         end else if (i_valid && (!issue || dmem.i_dmem_gnt)) begin
            if (issue && is_load) begin
               state        <= WAIT;
               ld_rd        <= i_rd;
               ld_reg_write <= i_reg_write;
               ld_f3        <= i_funct3;
               ld_off       <= off;
            end else begin
               o_wb_valid     <= 1'b1;
               o_wb_rd        <= i_rd;
               o_wb_reg_write <= i_reg_write && !is_mem;
               o_wb_data      <= i_alu_result;
               o_misaligned   <= is_mem && misaligned;
            end
         end
      end
   end
endmodule

// File: tb/tb_core_mem_stage.sv
// tb_core_mem_stage: directed plus random instructions against a transaction-level model of the memory stage.
module tb_core_mem_stage;
   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic [6:0]  i_opcode;
   logic [2:0]  i_funct3;
   logic [4:0]  i_rd;
   logic        i_reg_write;
   logic [31:0] i_alu_result;
   logic [31:0] i_store_data;
   logic        o_stall, o_misaligned, o_wb_valid, o_wb_reg_write;
   logic [4:0]  o_wb_rd;
   logic [31:0] o_wb_data;
   int checks = 0;
   int errors = 0;
   localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, ALU = 7'b0010011;

   core_mem_stage_if #(.XLEN(32)) dmem ();

   core_mem_stage #(.XLEN(32)) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_valid        (i_valid),
      .i_opcode       (i_opcode),
      .i_funct3       (i_funct3),
      .i_rd           (i_rd),
      .i_reg_write    (i_reg_write),
      .i_alu_result   (i_alu_result),
      .i_store_data   (i_store_data),
      .dmem           (dmem),
      .o_stall        (o_stall),
      .o_misaligned   (o_misaligned),
      .o_wb_valid     (o_wb_valid),
      .o_wb_rd        (o_wb_rd),
      .o_wb_reg_write (o_wb_reg_write),
      .o_wb_data      (o_wb_data)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   function automatic int unsigned size_of(input bit ld, input bit [2:0] f3);
      if (f3 == 3'd0 || (ld && f3 == 3'd4)) return 1;
      if (f3 == 3'd1 || (ld && f3 == 3'd5)) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] load_val(input bit [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
      int unsigned sz;
      logic [31:0] v;
      sz = size_of(1'b1, f3);
      v = rdata >> (8 * (addr % 4));
      if (sz == 1) begin
         v = v & 32'hFF;
         return (f3 == 3'd0) ? (v ^ 32'h80) - 32'h80 : v;
      end
      if (sz == 2) begin
         v = v & 32'hFFFF;
         return (f3 == 3'd1) ? (v ^ 32'h8000) - 32'h8000 : v;
      end
      return rdata;
   endfunction

   task automatic idle_inputs();
      i_valid = 1'b0;
      dmem.i_dmem_gnt = 1'b0;
      dmem.i_dmem_rvalid = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic rw, input logic [31:0] alu,
                         input logic [31:0] sd, input int gd, input int rvd, input logic [31:0] rdata);
      bit ld, st, mis;
      int unsigned sz;
      logic [31:0] exp_be, exp_wd;
      ld = op == LD;
      st = op == ST;
      sz = size_of(ld, f3);
      mis = (ld || st) && (alu % sz != 0);
      exp_be = ((32'd1 << sz) - 1) << (alu % 4);
      exp_wd = sz == 1 ? (sd & 32'hFF) * 32'h01010101 : sz == 2 ? (sd & 32'hFFFF) * 32'h00010001 : sd;
      i_valid = 1'b1; i_opcode = op; i_funct3 = f3; i_rd = rd;
      i_reg_write = rw; i_alu_result = alu; i_store_data = sd;
      if (!(ld || st) || mis) begin
         #1;
         chk({tag, ".req"}, dmem.o_dmem_req, 0);
         chk({tag, ".stall"}, o_stall, 0);
         tick();
         chk({tag, ".wb_valid"}, o_wb_valid, 1);
         chk({tag, ".misaligned"}, o_misaligned, mis);
         chk({tag, ".wb_reg_write"}, o_wb_reg_write, mis ? 1'b0 : rw);
         if (!mis) begin
            chk({tag, ".wb_rd"}, o_wb_rd, rd);
            chk({tag, ".wb_data"}, o_wb_data, alu);
         end
      end else begin
         for (int k = 0; k <= gd; k++) begin
            dmem.i_dmem_gnt = (k == gd);
            #1;
            chk({tag, ".req"}, dmem.o_dmem_req, 1);
            chk({tag, ".we"}, dmem.o_dmem_we, st);
            chk({tag, ".addr"}, dmem.o_dmem_addr, alu & ~32'h3);
            chk({tag, ".stall"}, o_stall, ld || k != gd);
            if (st) begin
               chk({tag, ".be"}, dmem.o_dmem_be, exp_be & 32'hF);
               chk({tag, ".wdata"}, dmem.o_dmem_wdata, exp_wd);
            end
            tick();
            if (k != gd || ld) chk({tag, ".wb_early"}, o_wb_valid, 0);
         end
         dmem.i_dmem_gnt = 1'b0;
         if (ld) begin
            for (int j = 0; j <= rvd; j++) begin
               dmem.i_dmem_rvalid = (j == rvd);
               dmem.i_dmem_rdata = (j == rvd) ? rdata : $urandom;
               #1;
               chk({tag, ".wait_req"}, dmem.o_dmem_req, 0);
               chk({tag, ".wait_stall"}, o_stall, j != rvd);
               tick();
            end
            dmem.i_dmem_rvalid = 1'b0;
            chk({tag, ".wb_rd"}, o_wb_rd, rd);
            chk({tag, ".wb_data"}, o_wb_data, load_val(f3, alu, rdata));
         end
         chk({tag, ".wb_valid"}, o_wb_valid, 1);
         chk({tag, ".wb_reg_write"}, o_wb_reg_write, ld ? rw : 1'b0);
         chk({tag, ".misaligned"}, o_misaligned, 0);
      end
      idle_inputs();
      tick();
      chk({tag, ".wb_pulse"}, o_wb_valid, 0);
      chk({tag, ".mis_pulse"}, o_misaligned, 0);
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_opcode = '0; i_funct3 = '0; i_rd = '0; i_reg_write = 1'b0;
      i_alu_result = '0; i_store_data = '0;
      dmem.i_dmem_rdata = '0;
      idle_inputs();
      tick();
      tick();
      chk("rst.wb_valid", o_wb_valid, 0);
      chk("rst.wb_data", o_wb_data, 0);
      chk("rst.wb_rd", o_wb_rd, 0);
      chk("rst.misaligned", o_misaligned, 0);
      chk("rst.req", dmem.o_dmem_req, 0);
      chk("rst.stall", o_stall, 0);
      i_rst_n = 1'b1;
      tick();

      run_op("addi", ALU, 3'd0, 5'd5, 1'b1, 32'h55, 32'h0, 0, 0, 32'h0);
      run_op("sb", ST, 3'd0, 5'd0, 1'b0, 32'h1003, 32'hAB, 2, 0, 32'h0);
      run_op("lb", LD, 3'd0, 5'd9, 1'b1, 32'h2001, 32'h0, 0, 1, 32'h0000_8000);
      run_op("lbu", LD, 3'd4, 5'd10, 1'b1, 32'h2001, 32'h0, 1, 1, 32'h0000_8000);
      run_op("lw_mis", LD, 3'd2, 5'd3, 1'b1, 32'h2002, 32'h0, 0, 0, 32'h0);
      run_op("sh_hi", ST, 3'd1, 5'd0, 1'b0, 32'h40A2, 32'h1234_BEEF, 0, 0, 32'h0);
      run_op("sw_f3x", ST, 3'd7, 5'd0, 1'b0, 32'h5000, 32'hCAFE_F00D, 1, 0, 32'h0);
      run_op("lh_neg", LD, 3'd1, 5'd11, 1'b1, 32'h6002, 32'h0, 0, 0, 32'h9ABC_1234);

      // rvalid while idle must not create a writeback
      dmem.i_dmem_rvalid = 1'b1;
      dmem.i_dmem_rdata = 32'hDEAD_BEEF;
      tick();
      chk("idle_rvalid.wb_valid", o_wb_valid, 0);
      dmem.i_dmem_rvalid = 1'b0;

      for (int n = 0; n < 40; n++) begin
         int unsigned kind;
         logic [6:0] op;
         kind = $urandom_range(0, 2);
         op = kind == 0 ? ALU : kind == 1 ? LD : ST;
         run_op("rand", op, 3'($urandom_range(0, 7)), 5'($urandom), 1'($urandom),
                $urandom, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $urandom);
      end

      run_op("addi2", ALU, 3'd0, 5'd17, 1'b1, 32'h1234_5678, 32'h0, 0, 0, 32'h0);
      i_valid = 1'b1; i_opcode = LD; i_funct3 = 3'd2; i_rd = 5'd7;
      i_reg_write = 1'b1; i_alu_result = 32'h3000;
      dmem.i_dmem_gnt = 1'b1;
      tick();
      dmem.i_dmem_gnt = 1'b0;
      #1;
      chk("wait.stall", o_stall, 1);
      i_rst_n = 1'b0;
      #1;
      chk("wait_rst.req", dmem.o_dmem_req, 0);
      chk("wait_rst.stall", o_stall, 0);
      chk("wait_rst.wb_valid", o_wb_valid, 0);
      chk("wait_rst.wb_rd", o_wb_rd, 0);
      chk("wait_rst.wb_reg_write", o_wb_reg_write, 0);
      chk("wait_rst.wb_data", o_wb_data, 0);
      chk("wait_rst.misaligned", o_misaligned, 0);
      tick();
      i_valid = 1'b0;
      i_rst_n = 1'b1;
      dmem.i_dmem_rvalid = 1'b1;
      dmem.i_dmem_rdata = 32'hFFFF_FFFF;
      #1;
      chk("late_rvalid.stall", o_stall, 0);
      tick();
      dmem.i_dmem_rvalid = 1'b0;
      chk("late_rvalid.wb_valid", o_wb_valid, 0);
      chk("late_rvalid.wb_data", o_wb_data, 0);
      run_op("post_rst", ALU, 3'd0, 5'd1, 1'b1, 32'hA5A5_0001, 32'h0, 0, 0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
